posit_add_sched: RTL
====================

POSIT_ADD_SCHED -- requirements
Module: posit_add_sched

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing one posit adder (2..8).
REQ-002 Parameter NBITS, default 32: posit width.
REQ-003 Parameter ADD_LAT, default 1: cycles from add_start to add_done of the attached adder (1..8).
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req_valid  in  NREQ  per-requester operation request.
REQ-007 req_in1, req_in2  in  NREQ*NBITS  operands; slice i belongs to requester i.
REQ-008 req_ready  out  NREQ  request accepted this cycle when valid&ready.
REQ-009 rsp_valid  out  NREQ  result held for requester i.
REQ-010 rsp_result  out  NREQ*NBITS  per-requester result register.
REQ-011 rsp_inf, rsp_zero  out  NREQ  per-requester flags.
REQ-012 rsp_ready  in  NREQ  result consumed when valid&ready.
REQ-013 add_start  out  1  issue pulse to adder.
REQ-014 add_in1, add_in2  out  NBITS  registered operands to adder.
REQ-015 add_done, add_inf, add_zero  in  1  adder completion and flags.
REQ-016 add_result  in  NBITS  adder sum.
REQ-017 err  out  1  sticky protocol error.

Function
REQ-018 Per requester, 2-bit FSM: IDLE -> BUSY on acceptance; BUSY -> RESP on tagged add_done; RESP -> IDLE on rsp_ready.
REQ-019 req_ready[i] SHALL be 1 only when FSM[i]==IDLE and i is the current grant.
REQ-020 Arbitration: round-robin among requesters with req_valid and IDLE; search starts at last_grant+1 modulo NREQ; at most one grant per cycle.
REQ-021 On grant, add_start, add_in1, add_in2 SHALL be registered next cycle (issue latency 1 cycle).
REQ-022 Granted requester id SHALL enter a tag shift register of depth ADD_LAT with valid bit, aligned with add_done.
REQ-023 When tag-valid emerges with add_done=1, result and flags SHALL be written to that requester's response slot and FSM moves to RESP.
REQ-024 Tag-valid without add_done, or add_done without tag-valid, SHALL set err and discard the cycle's data; err clears only on reset.
REQ-025 Back-to-back issue every cycle SHALL be supported; throughput one op/cycle with NREQ active requesters.
REQ-026 Requester in RESP with rsp_ready=1 SHALL be eligible for grant the following cycle, not the same cycle.
REQ-027 Simultaneous write of requester i's slot and rsp_ready for i cannot occur (FSM exclusive); no bypass path.
REQ-028 add_start SHALL be 0 in any cycle without a grant in the previous cycle.

Reset
REQ-029 Reset: all FSMs IDLE, last_grant=NREQ-1, tag register cleared, add_start=0, add_in1/add_in2=0, rsp_valid=0, rsp_result=0, rsp_inf=rsp_zero=0, err=0.
REQ-030 Reset mid-operation SHALL abandon in-flight ops; later add_done pulses without tag-valid after reset release SHALL set err.

Configuration
REQ-031 Macro POSIT_ADD_SCHED_STATS_EN: when defined, adds outputs stat_issued (32-bit, count of add_start) and stat_stall (32-bit, cycles with any req_valid&~req_ready), both saturating, reset to 0; when undefined these ports and counters SHALL not exist.

Structure
REQ-032 FSM state enum and tag struct (valid, id) SHALL live in posit_defines.
REQ-033 One sub-module rr_arbiter (NREQ-wide request vector in, one-hot grant out, registered pointer) SHALL be used.

Verification
REQ-034 Single request: req0 in1=0x40000000, in2=0x40000000, ADD_LAT=1, stub adder -> add_start cycle 1, rsp_valid[0] cycle 2 with 0x48000000.
REQ-035 All 4 requesters valid continuously -> grants 0,1,2,3,0... each response correctly routed; one add_start per cycle.
REQ-036 rsp_ready[2] held low 10 cycles -> requester 2 never re-granted until consumed; others unaffected.
REQ-037 Stub add_done forced with no issue -> err=1 and stays 1 until reset.
REQ-038 Reset asserted with 3 ops in flight (ADD_LAT=4) -> all outputs at reset values within the same cycle; no rsp_valid after release.
REQ-039 STATS_EN build: 5 issues plus 3 blocked cycles -> stat_issued=5, stat_stall=3.

Source files
------------

// File: rtl/posit_defines.sv
// Shared types for the posit adder scheduler: per-requester FSM states and issue tags.
package posit_defines;

  // Tag id is sized for the largest supported requester count (8).
  localparam int unsigned TagIdW = 3;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StResp = 2'd2
  } req_state_e;

  typedef struct packed {
    logic              valid;
    logic [TagIdW-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts one past the registered last grant.
module rr_arbiter #(
  parameter int unsigned NREQ = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] gnt_id
);

  localparam int unsigned IdW = $clog2(NREQ);

  logic [IdW-1:0] last_q, last_d;
  logic           found;

  always_comb begin
    gnt    = '0;
    gnt_id = last_q;
    found  = 1'b0;
    for (int k = 1; k <= int'(NREQ); k++) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (!found && req[i] && (i == (int'(last_q) + k) % int'(NREQ))) begin
          found  = 1'b1;
          gnt[i] = 1'b1;
          gnt_id = IdW'(i);
        end
      end
    end
  end

  assign last_d = found ? gnt_id : last_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= IdW'(NREQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/posit_add_sched.sv
// Round-robin scheduler sharing one pipelined posit adder among NREQ requesters.
// Define POSIT_ADD_SCHED_STATS_EN to add the stat_issued / stat_stall counters.
module posit_add_sched
  import posit_defines::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned NBITS   = 32,
  parameter int unsigned ADD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*NBITS-1:0] req_in1,
  input  logic [NREQ*NBITS-1:0] req_in2,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [NREQ*NBITS-1:0] rsp_result,
  output logic [NREQ-1:0]       rsp_inf,
  output logic [NREQ-1:0]       rsp_zero,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic                  add_start,
  output logic [NBITS-1:0]      add_in1,
  output logic [NBITS-1:0]      add_in2,
  input  logic                  add_done,
  input  logic                  add_inf,
  input  logic                  add_zero,
  input  logic [NBITS-1:0]      add_result,
  output logic                  err
`ifdef POSIT_ADD_SCHED_STATS_EN
  ,
  output logic [31:0]           stat_issued,
  output logic [31:0]           stat_stall
`endif
);

  localparam int unsigned IdW = $clog2(NREQ);

  req_state_e            state_q [NREQ];
  req_state_e            state_d [NREQ];
  logic [NREQ-1:0]       idle, elig, gnt, wr_en;
  logic [IdW-1:0]        gnt_id;
  logic [NBITS-1:0]      sel_in1, sel_in2;
  logic                  add_start_q;
  logic [NBITS-1:0]      add_in1_q, add_in2_q;
  tag_t                  tag_q [ADD_LAT];
  tag_t                  tag_in, tag_out;
  logic                  hit, proto_err, err_q;
  logic [NREQ*NBITS-1:0] rsp_result_q;
  logic [NREQ-1:0]       rsp_inf_q, rsp_zero_q;

  // Grants are masked during reset so req_ready reads 0 while reset is held.
  assign elig      = req_valid & idle & {NREQ{~reset}};
  assign req_ready = gnt;

  rr_arbiter #(
    .NREQ(NREQ)
  ) u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (elig),
    .gnt   (gnt),
    .gnt_id(gnt_id)
  );

  always_comb begin
    sel_in1 = '0;
    sel_in2 = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (gnt[i]) begin
        sel_in1 = req_in1[i*NBITS +: NBITS];
        sel_in2 = req_in2[i*NBITS +: NBITS];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      add_start_q <= 1'b0;
      add_in1_q   <= '0;
      add_in2_q   <= '0;
    end else begin
      add_start_q <= |gnt;
      if (|gnt) begin
        add_in1_q <= sel_in1;
        add_in2_q <= sel_in2;
      end
    end
  end

  assign add_start = add_start_q;
  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;

  // Tag enters alongside add_start; after ADD_LAT stages it lines up with add_done,
  // i.e. the adder signals done in the ADD_LAT-th cycle counting the add_start cycle.
  assign tag_in = '{valid: |gnt, id: TagIdW'(gnt_id)};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < int'(ADD_LAT); k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      tag_q[0] <= tag_in;
      for (int k = 1; k < int'(ADD_LAT); k++) begin
        tag_q[k] <= tag_q[k-1];
      end
    end
  end

  assign tag_out   = tag_q[ADD_LAT-1];
  assign hit       = tag_out.valid & add_done;
  assign proto_err = tag_out.valid ^ add_done;

  always_comb begin
    idle      = '0;
    wr_en     = '0;
    rsp_valid = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idle[i]      = (state_q[i] == StIdle);
      rsp_valid[i] = (state_q[i] == StResp);
      wr_en[i]     = hit && (tag_out.id == TagIdW'(i));
    end
  end

  always_comb begin
    for (int i = 0; i < int'(NREQ); i++) begin
      state_d[i] = state_q[i];
      case (state_q[i])
        StIdle:  if (gnt[i])       state_d[i] = StBusy;
        StBusy:  if (wr_en[i])     state_d[i] = StResp;
        StResp:  if (rsp_ready[i]) state_d[i] = StIdle;
        default: state_d[i] = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREQ); i++) begin
        state_q[i] <= StIdle;
      end
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        state_q[i] <= state_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_result_q <= '0;
      rsp_inf_q    <= '0;
      rsp_zero_q   <= '0;
    end else begin
      for (int i = 0; i < int'(NREQ); i++) begin
        if (wr_en[i]) begin
          rsp_result_q[i*NBITS +: NBITS] <= add_result;
          rsp_inf_q[i]                   <= add_inf;
          rsp_zero_q[i]                  <= add_zero;
        end
      end
    end
  end

  assign rsp_result = rsp_result_q;
  assign rsp_inf    = rsp_inf_q;
  assign rsp_zero   = rsp_zero_q;

  // A tag without done (or done without tag) drops that cycle's data; err is sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_q | proto_err;
    end
  end

  assign err = err_q;

`ifdef POSIT_ADD_SCHED_STATS_EN
  logic [31:0] issued_q, stall_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      if (add_start_q && (issued_q != '1)) begin
        issued_q <= issued_q + 32'd1;
      end
      if (|(req_valid & ~gnt) && (stall_q != '1)) begin
        stall_q <= stall_q + 32'd1;
      end
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule
